// File: rtl/mux16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter
//
// Round-robin arbiter and select sequencer for a shared 16:1 bit mux.
// Sixteen requesters compete for the mux output. One requester is granted at
// a time. The winner's index drives the mux select and stays stable for the
// whole grant. Every release is followed by exactly one dead (idle) cycle, so
// the select never moves while a consumer may still be sampling the mux output.
//
// Parameters
//   MAX_HOLD  maximum number of cycles a grant may last (0 = unlimited, 0..255)
//
// Ports
//   Clock   in   1   rising-edge clock
//   Resetn  in   1   asynchronous, active-low reset
//   req     in   16  request vector, req[i]=1 -> requester i wants the mux
//   done    in   1   granted requester releases the mux (pulse or level)
//   grant   out  16  one-hot grant, all zero while not granting
//   sel     out  4   mux select, index of the granted requester
//   valid   out  1   high while a grant is active (valid == |grant)
// ---------------------------------------------------------------------------
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Hold limit folded into a compare constant on the 8-bit grant counter.
    // The counter reads 0 in the first granted cycle, so the last allowed
    // cycle is MAX_HOLD-1.
    localparam logic       HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [3:0] last;
    logic [7:0] cnt;

    logic [4:0] pick;
    logic       release_now;

    // Round-robin scan: first set request starting just after 'from'.
    // The 4-bit add wraps naturally, so from=15 starts the scan at index 0,
    // and the final step (k=16) revisits 'from' itself as lowest priority.
    // Result is {found, index}.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] from);
        logic [3:0] idx;
        logic [4:0] res;
        res = 5'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = from + 4'(k);
            if (!res[4] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Saturating increment of the grant-length counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        pick        = rr_pick(req, last);
        release_now = done | ~req[sel] | (HOLD_EN && (cnt == HOLD_LAST));
    end

    // Registered state and outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
            grant <= 16'd0;
            sel   <= 4'd0;
            valid <= 1'b0;
            last  <= 4'd15;
            cnt   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // sel keeps its old value while idle so the mux input
                    // does not toggle during the dead cycle.
                    if (pick[4]) begin
                        state <= ST_BUSY;
                        grant <= 16'd1 << pick[3:0];
                        sel   <= pick[3:0];
                        valid <= 1'b1;
                        last  <= pick[3:0];
                        cnt   <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    cnt <= sat_inc(cnt);
                    // Release always returns to IDLE; new requests, even ones
                    // present in this same cycle, are arbitrated from IDLE,
                    // which produces the single dead cycle between grants.
                    if (release_now) begin
                        state <= ST_IDLE;
                        grant <= 16'd0;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 16'd0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Output invariants
    a_valid_grant : assert property (@(posedge Clock) disable iff (!Resetn)
        valid == (|grant));
    a_onehot      : assert property (@(posedge Clock) disable iff (!Resetn)
        $onehot0(grant));
    a_sel_match   : assert property (@(posedge Clock) disable iff (!Resetn)
        valid |-> (grant == (16'd1 << sel)));

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux16_rr_arbiter
//
// Three arbiters share one set of inputs: MAX_HOLD = 8, 4 and 0 (unlimited).
// Each is compared every cycle against a reference model that tracks the
// current owner (or none), how many cycles it has held the mux, and the most
// recent winner. Directed scenarios are followed by randomized traffic with
// occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_mux16_rr_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] req;
    logic        done;

    logic [15:0] grant_w [3];
    logic [3:0]  sel_w   [3];
    logic        valid_w [3];

    always #5 Clock = ~Clock;

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut_h8 (
        .Clock(Clock), .Resetn(Resetn), .req(req), .done(done),
        .grant(grant_w[0]), .sel(sel_w[0]), .valid(valid_w[0])
    );
    mux16_rr_arbiter #(.MAX_HOLD(4)) dut_h4 (
        .Clock(Clock), .Resetn(Resetn), .req(req), .done(done),
        .grant(grant_w[1]), .sel(sel_w[1]), .valid(valid_w[1])
    );
    mux16_rr_arbiter #(.MAX_HOLD(0)) dut_h0 (
        .Clock(Clock), .Resetn(Resetn), .req(req), .done(done),
        .grant(grant_w[2]), .sel(sel_w[2]), .valid(valid_w[2])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int hold_lim [3] = '{8, 4, 0};
    int m_owner  [3];   // -1 when nobody holds the mux
    int m_len    [3];   // cycles the owner has held the mux so far
    int m_last   [3];   // most recent winner
    int m_sel    [3];   // select value presented on the output

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1;
            m_len[d]   = 0;
            m_last[d]  = 15;
            m_sel[d]   = 0;
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        int  cand;
        bit  found;
        for (int d = 0; d < 3; d++) begin
            if (m_owner[d] < 0) begin
                found = 1'b0;
                for (int j = 1; j <= 16; j++) begin
                    cand = (m_last[d] + j) % 16;
                    if (!found && req[cand]) begin
                        found      = 1'b1;
                        m_owner[d] = cand;
                        m_last[d]  = cand;
                        m_sel[d]   = cand;
                        m_len[d]   = 1;
                    end
                end
            end else begin
                if (done || !req[m_owner[d]] || (hold_lim[d] != 0 && m_len[d] >= hold_lim[d]))
                    m_owner[d] = -1;
                else
                    m_len[d] = m_len[d] + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eg;
        for (int d = 0; d < 3; d++) begin
            eg = (m_owner[d] < 0) ? 16'd0 : (16'd1 << m_owner[d]);
            check_val($sformatf("%s_grant%0d", tag, d), grant_w[d], eg);
            check_val($sformatf("%s_sel%0d", tag, d), sel_w[d], m_sel[d]);
            check_val($sformatf("%s_valid%0d", tag, d), valid_w[d], (m_owner[d] >= 0));
        end
    endtask

    // One clock: model follows the inputs present at the edge, outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
        check_all("cyc");
    endtask

    task automatic wait_valid_h8(input int max_cycles);
        int n;
        n = 0;
        while (!valid_w[0] && n < max_cycles) begin
            tick();
            n++;
        end
        check_val("wait_grant", valid_w[0], 1'b1);
    endtask

    task automatic async_reset_pulse();
        Resetn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("arst_grant%0d", d), grant_w[d], 16'd0);
            check_val($sformatf("arst_valid%0d", d), valid_w[d], 1'b0);
            check_val($sformatf("arst_sel%0d", d), sel_w[d], 4'd0);
        end
        model_reset();
        #1;
        Resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        Resetn = 1'b0;
        req    = 16'd0;
        done   = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all("reset");
        Resetn = 1'b1;

        // Async reset in the middle of a grant on requester 4
        req = 16'h0010;
        tick();
        check_val("t1_grant", grant_w[0], 16'h0010);
        async_reset_pulse();
        req = 16'h0000;
        tick();

        // Single requester, done pulse in cycle 3
        req = 16'h0001;
        tick();
        check_val("t2_grant_c1", grant_w[0], 16'h0001);
        check_val("t2_sel_c1", sel_w[0], 4'd0);
        check_val("t2_valid_c1", valid_w[0], 1'b1);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("t2_valid_c4", valid_w[0], 1'b0);
        check_val("t2_grant_c4", grant_w[0], 16'h0000);
        req = 16'h0000;
        tick();
        tick();

        // Two persistent requesters alternate, one dead cycle between grants
        req = 16'h8001;
        for (int i = 0; i < 6; i++) begin
            wait_valid_h8(4);
            check_val("t3_alt_sel", sel_w[0], (i % 2 == 0) ? 4'd15 : 4'd0);
            done = 1'b1;
            tick();
            done = 1'b0;
            check_val("t3_dead", valid_w[0], 1'b0);
        end

        // Wrap-around from last=15
        req = 16'h8000;
        wait_valid_h8(4);
        check_val("t4_sel15", sel_w[0], 4'd15);
        done = 1'b1;
        req  = 16'h0024;
        tick();
        done = 1'b0;
        tick();
        check_val("t4_sel2", sel_w[0], 4'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_val("t4_sel5", sel_w[0], 4'd5);
        req = 16'h0000;
        tick();
        tick();

        // Withdrawn request hands the mux to a pending requester
        req = 16'h0008;
        wait_valid_h8(4);
        check_val("t6_sel3", sel_w[0], 4'd3);
        req = 16'h0088;
        tick();
        req = 16'h0080;
        tick();
        check_val("t6_drop", grant_w[0], 16'h0000);
        tick();
        check_val("t6_sel7", sel_w[0], 4'd7);
        check_val("t6_valid7", valid_w[0], 1'b1);
        req = 16'h0000;
        tick();
        tick();

        // Hold limit on the MAX_HOLD=4 instance
        req = 16'h0100;
        tick();
        check_val("t5_valid_1", valid_w[1], 1'b1);
        check_val("t5_sel", sel_w[1], 4'd8);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_val($sformatf("t5_valid_%0d", i), valid_w[1], 1'b1);
        end
        tick();
        check_val("t5_idle", valid_w[1], 1'b0);
        tick();
        check_val("t5_regrant", valid_w[1], 1'b1);
        check_val("t5_resel", sel_w[1], 4'd8);
        req = 16'h0000;
        tick();
        tick();

        // Randomized traffic
        r = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 4))
                0: r = 16'h0000;
                1: r = 16'd1 << $urandom_range(0, 15);
                2: r = 16'($urandom);
                default: r = r;
            endcase
            req  = r;
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0)
                async_reset_pulse();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
